offchip_mem_responder: RTL and testbench

OFFCHIP_MEM_RESPONDER -- requirements
Module: offchip_mem_responder

---
 rtl/offchip_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_offchip_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/offchip_mem_responder.sv
// Line-to-word bridge: serves 128-bit line reads and writes as 32-bit backend word bursts, acked per word.
// Latency: the sum of per-word ack latencies + 2 cycles from acceptance to ready. The backend stalls by holding bus_ack low.
// Optional OFFCHIP_ACK_TIMEOUT_EN: aborts a word after TIMEOUT_CYC cycles without an ack, flagged on offchip_mem_err.
module offchip_mem_responder #(
    parameter int LINE_WORDS  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     offchip_mem_read_en,
    input  logic                     offchip_mem_write_en,
    input  logic [31:0]              offchip_mem_addr,
    input  logic [LINE_WORDS*32-1:0] offchip_mem_wdata,
    output logic [LINE_WORDS*32-1:0] offchip_mem_data,
    output logic                     offchip_mem_ready,
    output logic                     offchip_mem_err,
    output logic [31:0]              bus_addr,
    output logic [31:0]              bus_wdata,
    output logic                     bus_re,
    output logic                     bus_we,
    input  logic [31:0]              bus_rdata,
    input  logic                     bus_ack
);
    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;

    logic [1:0]              state;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [31:0]             base;
    logic [31:0]             line_base;
    logic [31:0]             next_addr;
    logic [31:0]             wwords [LINE_WORDS];
    logic [31:0]             rwords [LINE_WORDS];
    logic [LINE_WORDS*32-1:0] rd_line_nxt;
    logic                    rd_served;
    logic                    wr_served;
    logic                    resp_rd;
    logic                    in_burst;
    logic                    timeout_hit;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^offchip_mem_addr[3:0];
    assign line_base = {offchip_mem_addr[31:4], 4'b0000};
    assign cnt_nxt   = cnt + 1'b1;
    assign next_addr = base + {{(30-CW){1'b0}}, cnt_nxt, 2'b00};
    assign in_burst  = (state == RD_BURST) || (state == WR_BURST);

    // Completed line includes the word arriving on this ack.
    always_comb begin
        rd_line_nxt = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            rd_line_nxt[i*32 +: 32] = (cnt == CW'(i)) ? bus_rdata : rwords[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= '0;
            base              <= '0;
            rd_served         <= 1'b0;
            wr_served         <= 1'b0;
            resp_rd           <= 1'b0;
            offchip_mem_data  <= '0;
            offchip_mem_ready <= 1'b0;
            bus_addr          <= '0;
            bus_wdata         <= '0;
            bus_re            <= 1'b0;
            bus_we            <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                wwords[i] <= '0;
                rwords[i] <= '0;
            end
        end else begin
            offchip_mem_ready <= 1'b0;

            // A served request must drop before it can be accepted again.
            if (!offchip_mem_write_en)
                wr_served <= 1'b0;
            else if (state == RESP && !resp_rd)
                wr_served <= 1'b1;
            if (!offchip_mem_read_en)
                rd_served <= 1'b0;
            else if (state == RESP && resp_rd)
                rd_served <= 1'b1;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (offchip_mem_write_en && !wr_served) begin
                        base      <= line_base;
                        bus_addr  <= line_base;
                        bus_wdata <= offchip_mem_wdata[31:0];
                        bus_we    <= 1'b1;
                        resp_rd   <= 1'b0;
                        state     <= WR_BURST;
                        for (int i = 0; i < LINE_WORDS; i++)
                            wwords[i] <= offchip_mem_wdata[i*32 +: 32];
                    end else if (offchip_mem_read_en && !rd_served) begin
                        base     <= line_base;
                        bus_addr <= line_base;
                        bus_re   <= 1'b1;
                        resp_rd  <= 1'b1;
                        state    <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (bus_ack) begin
                        rwords[cnt] <= bus_rdata;
                        if (cnt == LAST_WORD) begin
                            bus_re           <= 1'b0;
                            offchip_mem_data <= rd_line_nxt;
                            state            <= RESP;
                        end else begin
                            cnt      <= cnt_nxt;
                            bus_addr <= next_addr;
                        end
                    end else if (timeout_hit) begin
                        bus_re <= 1'b0;
                        state  <= RESP;
                    end
                end
                WR_BURST: begin
                    if (bus_ack) begin
                        if (cnt == LAST_WORD) begin
                            bus_we <= 1'b0;
                            state  <= RESP;
                        end else begin
                            cnt       <= cnt_nxt;
                            bus_addr  <= next_addr;
                            bus_wdata <= wwords[cnt_nxt];
                        end
                    end else if (timeout_hit) begin
                        bus_we <= 1'b0;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    offchip_mem_ready <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OFFCHIP_ACK_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [TW-1:0] wait_cnt;
    logic          resp_err;
    logic          err_q;

    assign timeout_hit     = in_burst && !bus_ack && (wait_cnt == TW'(TIMEOUT_CYC - 1));
    assign offchip_mem_err = err_q;

    // Wait count restarts for every word, so the limit applies per word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            resp_err <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (in_burst && !bus_ack && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout_hit)
                resp_err <= 1'b1;
            else if (state == IDLE)
                resp_err <= 1'b0;
            err_q <= (state == RESP) && resp_err;
        end
    end
`else
    logic [31:0] unused_timeout;
    logic        unused_in_burst;

    assign unused_timeout  = TIMEOUT_CYC;
    assign unused_in_burst = in_burst;
    assign timeout_hit     = 1'b0;
    assign offchip_mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_offchip_mem_responder.sv
// Directed bench for offchip_mem_responder: a backend word model with per-word ack latency, plus scenario tasks.
module tb_offchip_mem_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         read_en = 1'b0;
    logic         write_en = 1'b0;
    logic [31:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic [127:0] data;
    logic         ready;
    logic         err;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_re;
    logic         bus_we;
    logic [31:0]  bus_rdata = '0;
    logic         bus_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int          lat [4];
    bit          no_ack = 1'b0;
    logic [31:0] rd_base = 32'hA000_0000;
    int          hold = 0;
    logic [31:0] log_addr [$];
    logic [31:0] log_wdata [$];
    bit          log_we [$];

    offchip_mem_responder #(.LINE_WORDS(4), .TIMEOUT_CYC(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .offchip_mem_read_en  (read_en),
        .offchip_mem_write_en (write_en),
        .offchip_mem_addr     (addr),
        .offchip_mem_wdata    (wdata),
        .offchip_mem_data     (data),
        .offchip_mem_ready    (ready),
        .offchip_mem_err      (err),
        .bus_addr             (bus_addr),
        .bus_wdata            (bus_wdata),
        .bus_re               (bus_re),
        .bus_we               (bus_we),
        .bus_rdata            (bus_rdata),
        .bus_ack              (bus_ack)
    );

    always #5 clk = ~clk;

    // Backend: acks a held strobe after lat[word] cycles, rdata = rd_base + word index.
    always @(negedge clk) begin
        if (!rst) begin
            hold    = 0;
            bus_ack = 1'b0;
        end else if ((bus_re || bus_we) && !no_ack) begin
            if (hold >= lat[bus_addr[3:2]] - 1) begin
                bus_ack   = 1'b1;
                bus_rdata = rd_base + {30'd0, bus_addr[3:2]};
                hold      = 0;
                log_addr.push_back(bus_addr);
                log_wdata.push_back(bus_wdata);
                log_we.push_back(bus_we);
            end else begin
                bus_ack = 1'b0;
                hold++;
            end
        end else begin
            bus_ack = 1'b0;
            hold    = 0;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_we.delete();
    endtask

    task automatic wait_ready(output int cyc, output int re_n, output int we_n,
                              output logic err_at, output logic [127:0] data_at, output logic stb_at);
        cyc = -1; re_n = 0; we_n = 0; err_at = 1'b0; data_at = '0; stb_at = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (ready) begin
                cyc = c; err_at = err; data_at = data; stb_at = bus_re | bus_we;
                break;
            end
            if (bus_re) re_n++;
            if (bus_we) we_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if ({bus_re, bus_we} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {bus_re, bus_we}); end
        n_cmp++; if ({bus_addr, bus_wdata} !== 64'd0) begin n_bad++; $display("FAIL reset_bus: got %h want 0", {bus_addr, bus_wdata}); end
        n_cmp++; if (data !== 128'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        int cyc, re_n, we_n, extra_re, extra_rdy;
        logic e; logic [127:0] d; logic s;
        rd_base = 32'hA000_0000;
        clear_log();
        addr = 32'h0000_1234;
        read_en = 1'b1;
        wait_ready(cyc, re_n, we_n, e, d, s);
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL read_latency: got %0d want 6", cyc); end
        n_cmp++; if (d !== 128'hA0000003_A0000002_A0000001_A0000000) begin n_bad++; $display("FAIL read_data: got %h want A0000003A0000002A0000001A0000000", d); end
        n_cmp++; if (e !== 1'b0 || s !== 1'b0) begin n_bad++; $display("FAIL read_err_stb: got err=%b stb=%b want 0 0", e, s); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL read_pulse_width: got %b want 0", ready); end
        n_cmp++; if (log_addr.size() !== 4) begin n_bad++; $display("FAIL read_words: got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            n_cmp++;
            if (log_addr[i] !== 32'h1230 + 32'(4 * i) || log_we[i] !== 1'b0) begin
                n_bad++; $display("FAIL read_addr%0d: got %h we=%b want %h we=0", i, log_addr[i], log_we[i], 32'h1230 + 32'(4 * i));
            end
        end
        extra_re = 0; extra_rdy = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_re) extra_re++;
            if (ready) extra_rdy++;
        end
        n_cmp++; if (extra_re !== 0 || extra_rdy !== 0) begin n_bad++; $display("FAIL read_no_reread: got re=%0d rdy=%0d want 0 0", extra_re, extra_rdy); end
    endtask

    task automatic test_write_back();
        int cyc, re_n, we_n, extra;
        logic e; logic [127:0] d; logic s;
        clear_log();
        addr = 32'h0000_2000;
        wdata = 128'h44444444_33333333_22222222_11111111;
        write_en = 1'b1;
        wait_ready(cyc, re_n, we_n, e, d, s);
        n_cmp++; if (cyc !== 6 || we_n !== 4 || re_n !== 0) begin n_bad++; $display("FAIL wb_latency: got cyc=%0d we=%0d re=%0d want 6 4 0", cyc, we_n, re_n); end
        n_cmp++; if (d !== 128'hA0000003_A0000002_A0000001_A0000000) begin n_bad++; $display("FAIL wb_data_kept: got %h want A0000003A0000002A0000001A0000000", d); end
        n_cmp++; if (log_addr.size() !== 4) begin n_bad++; $display("FAIL wb_words: got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            n_cmp++;
            if (log_addr[i] !== 32'h2000 + 32'(4 * i) || log_we[i] !== 1'b1 || log_wdata[i] !== 32'h1111_1111 * 32'(i + 1)) begin
                n_bad++; $display("FAIL wb_word%0d: got addr=%h we=%b wd=%h want %h 1 %h", i, log_addr[i], log_we[i], log_wdata[i], 32'h2000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            end
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready || bus_re || bus_we) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL wb_single: got %0d busy cycles want 0", extra); end
        read_en = 1'b0; write_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_both();
        int cyc, re_n, we_n, extra;
        logic e; logic [127:0] d; logic s;
        rd_base = 32'hB000_0000;
        clear_log();
        addr = 32'h0000_3000;
        wdata = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
        read_en = 1'b1; write_en = 1'b1;
        wait_ready(cyc, re_n, we_n, e, d, s);
        n_cmp++; if (cyc !== 6 || we_n !== 4 || re_n !== 0) begin n_bad++; $display("FAIL both_first_write: got cyc=%0d we=%0d re=%0d want 6 4 0", cyc, we_n, re_n); end
        n_cmp++; if (d !== 128'hA0000003_A0000002_A0000001_A0000000) begin n_bad++; $display("FAIL both_data_after_write: got %h want A0000003A0000002A0000001A0000000", d); end
        wait_ready(cyc, re_n, we_n, e, d, s);
        n_cmp++; if (cyc !== 6 || re_n !== 4 || we_n !== 0) begin n_bad++; $display("FAIL both_second_read: got cyc=%0d re=%0d we=%0d want 6 4 0", cyc, re_n, we_n); end
        n_cmp++; if (d !== 128'hB0000003_B0000002_B0000001_B0000000) begin n_bad++; $display("FAIL both_read_data: got %h want B0000003B0000002B0000001B0000000", d); end
        n_cmp++; if (log_addr.size() !== 8) begin n_bad++; $display("FAIL both_words: got %0d want 8", log_addr.size()); end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            n_cmp++;
            if (log_addr[i] !== 32'h3000 + 32'(4 * (i % 4)) || log_we[i] !== (i < 4)) begin
                n_bad++; $display("FAIL both_order%0d: got addr=%h we=%b want %h we=%0d", i, log_addr[i], log_we[i], 32'h3000 + 32'(4 * (i % 4)), (i < 4));
            end
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL both_extra_ready: got %0d want 0", extra); end
        read_en = 1'b0; write_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_timeout();
`ifdef OFFCHIP_ACK_TIMEOUT_EN
        int cyc, re_n, we_n;
        logic e; logic [127:0] d; logic s;
        no_ack = 1'b1;
        addr = 32'h0000_5000;
        read_en = 1'b1;
        wait_ready(cyc, re_n, we_n, e, d, s);
        n_cmp++; if (cyc !== 10 || re_n !== 8) begin n_bad++; $display("FAIL timeout_timing: got cyc=%0d re=%0d want 10 8", cyc, re_n); end
        n_cmp++; if (e !== 1'b1 || s !== 1'b0) begin n_bad++; $display("FAIL timeout_err: got err=%b stb=%b want 1 0", e, s); end
        n_cmp++; if (d !== 128'hB0000003_B0000002_B0000001_B0000000) begin n_bad++; $display("FAIL timeout_data_kept: got %h want B0000003B0000002B0000001B0000000", d); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL timeout_err_pulse: got err=%b rdy=%b want 0 0", err, ready); end
        read_en = 1'b0; no_ack = 1'b0;
        repeat (2) @(negedge clk);
`else
        int re_n, rdy_n, err_n;
        no_ack = 1'b1;
        addr = 32'h0000_5000;
        read_en = 1'b1;
        @(negedge clk);
        re_n = 0; rdy_n = 0; err_n = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus_re) re_n++;
            if (ready) rdy_n++;
            if (err) err_n++;
        end
        n_cmp++; if (re_n !== 300 || rdy_n !== 0) begin n_bad++; $display("FAIL no_timeout_hold: got re=%0d rdy=%0d want 300 0", re_n, rdy_n); end
        n_cmp++; if (err_n !== 0) begin n_bad++; $display("FAIL no_timeout_err: got %0d want 0", err_n); end
        read_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        no_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid();
        int cyc, re_n, we_n, seen;
        logic e; logic [127:0] d; logic s;
        rd_base = 32'hC000_0000;
        lat[2] = 3;
        clear_log();
        addr = 32'h0000_4000;
        read_en = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus_re && bus_addr == 32'h4008) begin seen = 1; break; end
        end
        n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL mid_reach_word2: got %0d want 1", seen); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if ({bus_re, bus_we, ready, err} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_flags: got %b want 0000", {bus_re, bus_we, ready, err}); end
        n_cmp++; if (bus_addr !== 32'd0 || data !== 128'd0) begin n_bad++; $display("FAIL mid_rst_addr_data: got %h %h want 0 0", bus_addr, data); end
        n_cmp++; if (log_addr.size() !== 2) begin n_bad++; $display("FAIL mid_rst_words_done: got %0d want 2", log_addr.size()); end
        repeat (2) @(negedge clk);
        lat[2] = 1;
        clear_log();
        rst = 1'b1;
        wait_ready(cyc, re_n, we_n, e, d, s);
        n_cmp++; if (cyc !== 6 || re_n !== 4) begin n_bad++; $display("FAIL mid_fresh_latency: got cyc=%0d re=%0d want 6 4", cyc, re_n); end
        n_cmp++; if (d !== 128'hC0000003_C0000002_C0000001_C0000000) begin n_bad++; $display("FAIL mid_fresh_data: got %h want C0000003C0000002C0000001C0000000", d); end
        n_cmp++; if (log_addr.size() !== 4 || (log_addr.size() > 0 && log_addr[0] !== 32'h4000)) begin n_bad++; $display("FAIL mid_fresh_words: got n=%0d want 4 starting 00004000", log_addr.size()); end
        read_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) lat[i] = 1;
        test_reset();
        test_read();
        test_write_back();
        test_both();
        test_ack_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
